// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller.
// Issues one data-cache request per memory instruction, stalls the pipeline
// until dhit, holds the completed result until the pipeline advances,
// resolves branch/jump redirects and latches a sticky halt.
module mem_stage_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ex_valid,
    input  logic             ex_MemRead,
    input  logic             ex_MemWrite,
    input  logic             ex_Branch,
    input  logic             ex_beq,
    input  logic             ex_bne,
    input  logic             ex_zero,
    input  logic             ex_jump,
    input  logic             ex_jr,
    input  logic             ex_halt,
    input  logic [31:0]      ex_PortOut,
    input  logic [31:0]      ex_rdat2,
    input  logic [31:0]      ex_rdat1,
    input  logic [31:0]      ex_BranchAddr,
    input  logic [31:0]      ex_JumpAddr,
    input  logic             pipe_en,
    input  logic             flush,
    input  logic             dhit,
    input  logic [31:0]      dmemload,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic             mem_stall,
    output logic [31:0]      load_data,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic memop;
    logic taken;
    logic capture;

    // Address and store data pass straight through; only meaningful with REN/WEN.
    assign dmemaddr  = ex_PortOut;
    assign dmemstore = ex_rdat2;

    // Memory-op qualification and branch condition.
    always_comb begin
        memop = ex_valid & (ex_MemRead | ex_MemWrite) & ~halt;
        taken = ex_Branch & ((ex_beq & ex_zero) | (ex_bne & ~ex_zero));
    end

    // Cache request and stall; WAIT keeps the request up even after halt so
    // an in-flight access is never abandoned. Read wins if both are set.
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_stall = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                dmemREN   = memop & ex_MemRead;
                dmemWEN   = memop & ex_MemWrite & ~ex_MemRead;
                mem_stall = memop & ~dhit;
                capture   = memop & dhit & ex_MemRead;
            end
            WAIT: begin
                dmemREN   = ex_MemRead;
                dmemWEN   = ex_MemWrite & ~ex_MemRead;
                mem_stall = ~dhit;
                capture   = dhit & ex_MemRead;
            end
            default: begin
                dmemREN   = 1'b0;
                dmemWEN   = 1'b0;
                mem_stall = 1'b0;
                capture   = 1'b0;
            end
        endcase
    end

    // Redirect resolution: jr beats jump beats branch.
    always_comb begin
        redirect    = ex_valid & ~flush & ~halt & (taken | ex_jump | ex_jr);
        redirect_pc = 32'h0;
        if (ex_jr)
            redirect_pc = ex_rdat1;
        else if (ex_jump)
            redirect_pc = ex_JumpAddr;
        else if (taken)
            redirect_pc = ex_BranchAddr;
    end

    // State machine plus registered load result, sticky halt and stall counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= IDLE;
            load_data    <= 32'h0;
            halt         <= 1'b0;
            stall_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        if (dhit)
                            state <= pipe_en ? IDLE : DONE;
                        else
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    // flush without dhit is ignored until the access finishes
                    if (dhit)
                        state <= (pipe_en | flush) ? IDLE : DONE;
                end
                DONE: begin
                    if (pipe_en | flush)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (capture)
                load_data <= dmemload;

            if (ex_valid & ex_halt & ~flush)
                halt <= 1'b1;

            if (mem_stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a load-result scoreboard.
module tb_mem_stage_ctrl;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ex_valid, ex_MemRead, ex_MemWrite, ex_Branch;
    logic             ex_beq, ex_bne, ex_zero, ex_jump, ex_jr, ex_halt;
    logic [31:0]      ex_PortOut, ex_rdat2, ex_rdat1, ex_BranchAddr, ex_JumpAddr;
    logic             pipe_en, flush, dhit;
    logic [31:0]      dmemload;
    logic             dmemREN, dmemWEN, mem_stall, redirect, halt;
    logic [31:0]      dmemaddr, dmemstore, load_data, redirect_pc;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int ren_cnt, stall_cnt;

    mem_stage_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_zero(ex_zero),
        .ex_jump(ex_jump), .ex_jr(ex_jr), .ex_halt(ex_halt),
        .ex_PortOut(ex_PortOut), .ex_rdat2(ex_rdat2), .ex_rdat1(ex_rdat1),
        .ex_BranchAddr(ex_BranchAddr), .ex_JumpAddr(ex_JumpAddr),
        .pipe_en(pipe_en), .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .load_data(load_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_MemRead = 0; ex_MemWrite = 0; ex_Branch = 0;
        ex_beq = 0; ex_bne = 0; ex_zero = 0; ex_jump = 0; ex_jr = 0; ex_halt = 0;
        ex_PortOut = 0; ex_rdat2 = 0; ex_rdat1 = 0; ex_BranchAddr = 0; ex_JumpAddr = 0;
        pipe_en = 0; flush = 0; dhit = 0; dmemload = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        clear_inputs();
        tick();
        tick();
        nRST = 1;
    endtask

    initial begin
        #2;
        do_reset();

        // Reset state
        check("rst_load", load_data, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_stall", {16'b0, stall_cycles}, 32'h0);
        check("rst_ren", {31'b0, dmemREN}, 32'h0);

        // Load: dhit three cycles after request, pipe_en with dhit
        ex_valid = 1; ex_MemRead = 1; ex_PortOut = 32'h40;
        dmemload = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        ren_cnt = 0; stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            dhit = (c == 3); pipe_en = (c == 3);
            settle();
            if (c == 0) check("ld_addr", dmemaddr, 32'h40);
            ren_cnt += int'(dmemREN);
            stall_cnt += int'(mem_stall);
            tick();
        end
        check("ld_ren_cycles", ren_cnt, 4);
        check("ld_stall_cyc", stall_cnt, 3);
        check("ld_data", load_data, exp_q.pop_front());
        check("ld_stall_cnt", {16'b0, stall_cycles}, 32'd3);
        // still IDLE: the next load is requested immediately
        dhit = 0; pipe_en = 0; settle();
        check("ld_idle_probe", {31'b0, dmemREN}, 32'h1);
        clear_inputs();

        // Store with pipe_en low at dhit, pipe_en at cycle 5
        ex_valid = 1; ex_MemWrite = 1; ex_PortOut = 32'h80; ex_rdat2 = 32'h12345678;
        for (int c = 1; c <= 5; c++) begin
            dhit = (c == 2); pipe_en = (c == 5);
            settle();
            if (c == 1) check("st_data", dmemstore, 32'h12345678);
            check($sformatf("st_wen_c%0d", c), {31'b0, dmemWEN}, (c <= 2) ? 32'h1 : 32'h0);
            tick();
        end
        dhit = 0; pipe_en = 0; settle();
        check("st_idle_probe", {31'b0, dmemWEN}, 32'h1);
        check("st_stall_cnt", {16'b0, stall_cycles}, 32'd4);
        clear_inputs();

        // Zero-wait read hit
        ex_valid = 1; ex_MemRead = 1; ex_PortOut = 32'hC0;
        dhit = 1; pipe_en = 1; dmemload = 32'hCAFEF00D;
        exp_q.push_back(32'hCAFEF00D);
        settle();
        check("zw_stall", {31'b0, mem_stall}, 32'h0);
        tick();
        check("zw_data", load_data, exp_q.pop_front());
        check("zw_stall_cnt", {16'b0, stall_cycles}, 32'd4);
        clear_inputs();

        // Branch / jump resolution
        ex_valid = 1; ex_Branch = 1; ex_bne = 1; ex_zero = 0; ex_BranchAddr = 32'h100;
        settle();
        check("bne_redir", {31'b0, redirect}, 32'h1);
        check("bne_pc", redirect_pc, 32'h100);
        ex_zero = 1; settle();
        check("bne_nt_redir", {31'b0, redirect}, 32'h0);
        flush = 1; ex_zero = 0; settle();
        check("bne_flush", {31'b0, redirect}, 32'h0);
        clear_inputs();
        ex_valid = 1; ex_jr = 1; ex_jump = 1; ex_rdat1 = 32'h200; ex_JumpAddr = 32'h300;
        settle();
        check("jr_redir", {31'b0, redirect}, 32'h1);
        check("jr_pc", redirect_pc, 32'h200);
        ex_jr = 0; settle();
        check("j_pc", redirect_pc, 32'h300);
        clear_inputs();

        // Halt: pulse, then memop and jump must be suppressed
        ex_valid = 1; ex_halt = 1;
        tick();
        ex_halt = 0; ex_MemRead = 1; ex_jump = 1; ex_JumpAddr = 32'h44;
        settle();
        check("halt_set", {31'b0, halt}, 32'h1);
        check("halt_ren", {31'b0, dmemREN}, 32'h0);
        check("halt_stall", {31'b0, mem_stall}, 32'h0);
        check("halt_redir", {31'b0, redirect}, 32'h0);
        ex_MemRead = 0; ex_MemWrite = 1; tick(); tick();
        check("halt_wen", {31'b0, dmemWEN}, 32'h0);
        check("halt_sticky", {31'b0, halt}, 32'h1);
        do_reset();
        check("halt_clr", {31'b0, halt}, 32'h0);

        // Flush in WAIT: held until dhit, then IDLE (no DONE)
        ex_valid = 1; ex_MemRead = 1; ex_PortOut = 32'h50; dmemload = 32'h0BADF00D;
        exp_q.push_back(32'h0BADF00D);
        tick();                      // request, miss -> WAIT
        flush = 1; settle();
        check("fl_ren_held", {31'b0, dmemREN}, 32'h1);
        check("fl_stall", {31'b0, mem_stall}, 32'h1);
        tick();
        dhit = 1; settle();
        check("fl_ren_hit", {31'b0, dmemREN}, 32'h1);
        tick();
        check("fl_data", load_data, exp_q.pop_front());
        flush = 0; dhit = 0; settle();
        check("fl_idle_probe", {31'b0, dmemREN}, 32'h1);
        dhit = 1; pipe_en = 1; tick();
        clear_inputs();

        // Saturation of the stall counter
        do_reset();
        ex_valid = 1; ex_MemRead = 1;
        for (int c = 0; c < 65535; c++) tick();
        check("sat_reach", {16'b0, stall_cycles}, 32'h0000FFFF);
        for (int c = 0; c < 6; c++) tick();
        check("sat_hold", {16'b0, stall_cycles}, 32'h0000FFFF);
        dhit = 1; pipe_en = 1; tick();
        clear_inputs();

        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage controller; consumes the EX/MEM pipeline register outputs and drives the data-cache request port. Issues exactly one dcache read/write per memory instruction and stalls the pipeline until dhit. Holds the completed result until the pipeline advances. Also resolves branch/jump redirects and latches halt.

Parameters:
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset; synchronous, active-low
ex_valid  in  1  EX/MEM register holds a live instruction
ex_MemRead  in  1  load
ex_MemWrite  in  1  store
ex_Branch  in  1  conditional branch
ex_beq  in  1  branch-if-equal
ex_bne  in  1  branch-if-not-equal
ex_zero  in  1  ALU zero flag
ex_jump  in  1  j/jal
ex_jr  in  1  jr
ex_halt  in  1  halt instruction
ex_PortOut  in  32  ALU result / memory address
ex_rdat2  in  32  store data
ex_rdat1  in  32  jr target
ex_BranchAddr  in  32  branch target
ex_JumpAddr  in  32  jump target
pipe_en  in  1  EX/MEM→MEM/WB advances this cycle
flush  in  1  squash current MEM instruction
dhit  in  1  dcache access complete
dmemload  in  32  dcache read data
dmemREN  out  1  dcache read request
dmemWEN  out  1  dcache write request
dmemaddr  out  32  = ex_PortOut
dmemstore  out  32  = ex_rdat2
mem_stall  out  1  freeze upstream stages
load_data  out  32  registered load result
redirect  out  1  PC must be redirected
redirect_pc  out  32  redirect target
halt  out  1  sticky halt
stall_cycles  out  CNT_W  saturating count of mem_stall cycles

Behaviour:
- Reset (nRST=0 at CLK edge): state=IDLE, load_data=0, halt=0, stall_cycles=0. Combinational outputs then follow with state=IDLE.
- memop = ex_valid & (ex_MemRead | ex_MemWrite) & ~halt. MemRead and MemWrite are never both set; if both are set, read wins.
- States: IDLE, WAIT, DONE.
- IDLE: dmemREN = memop & ex_MemRead; dmemWEN = memop & ex_MemWrite & ~ex_MemRead. mem_stall = memop & ~dhit.
  - memop & dhit: capture dmemload into load_data (reads only). Stay IDLE if pipe_en, else go to DONE.
  - memop & ~dhit: go to WAIT.
- WAIT: request held with the same REN/WEN/addr/data; mem_stall = ~dhit.
  - dhit: capture on a read. Go to IDLE if pipe_en or flush, else go to DONE.
  - flush while dhit=0 is ignored; the transaction is never abandoned.
- DONE: dmemREN=dmemWEN=0, mem_stall=0. Go to IDLE on pipe_en or flush. No second request for the same instruction.
- Zero-wait hit (dhit in the same cycle as the request) costs no stall cycle.
- dmemaddr/dmemstore are driven continuously from the inputs. They are only meaningful while REN/WEN is high.
- Branch resolution:
  - taken = ex_Branch & ((ex_beq & ex_zero) | (ex_bne & ~ex_zero)).
  - redirect = ex_valid & ~flush & ~halt & (taken | ex_jump | ex_jr). Combinational; valid in every state.
  - redirect_pc priority: jr→ex_rdat1, else jump→ex_JumpAddr, else branch→ex_BranchAddr, else 0.
- halt: set on the first edge where ex_valid & ex_halt & ~flush. Cleared only by reset. While set, no new requests and redirect=0. An access in WAIT still completes.
- stall_cycles: +1 on every edge where mem_stall=1; saturates at all-ones.
- Reset mid-WAIT returns to IDLE; the cache-side cleanup is the cache's responsibility.

Test Plan:
- Load: addr 0x40, dhit 3 cycles after the request, pipe_en with dhit, dmemload=0xDEADBEEF → dmemREN high 4 cycles, mem_stall high 3, load_data=0xDEADBEEF, stall_cycles=3, back to IDLE.
- Store with pipe_en low at dhit: ex_rdat2=0x12345678 @0x80, dhit cycle 2, pipe_en at cycle 5 → dmemWEN high exactly cycles 1–2; DONE cycles 3–5 with WEN=0 (no re-issue); IDLE after.
- Zero-wait hit: read with dhit same cycle, pipe_en=1 → mem_stall never 1, stall_cycles unchanged, load_data updated next edge.
- Branch: ex_Branch=1, ex_bne=1, ex_zero=0, BranchAddr=0x100 → redirect=1, redirect_pc=0x100. Same with ex_zero=1 → redirect=0. ex_jr=1 & ex_jump=1, rdat1=0x200 → redirect_pc=0x200.
- Halt: ex_halt pulse, then memop presented → halt=1 sticky, dmemREN/WEN stay 0, redirect=0. nRST low → halt=0.
- Flush in WAIT: flush asserted 1 cycle before dhit → request held until dhit, then IDLE with no DONE. Saturation: force 2^16+5 stall cycles → stall_cycles=0xFFFF.
